// File: rtl/c3aibadapt_avmm_dcg_pkg.sv
// Shared definitions for the AVMM dynamic clock gating requester:
// state encodings, testbus layout and default wake/idle cycle counts.
package c3aibadapt_avmm_dcg_pkg;

  // Default timing; the DCG-side wait count is derived from the same values.
  localparam int DCG_WAKE_CYC_DEF = 4;
  localparam int DCG_IDLE_CYC_DEF = 16;
  localparam int DCG_CNT_W_DEF    = 5;

  // Fixed 3-bit state codes; they are exposed on the testbus.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY   = 3'd1;
  localparam logic [2:0] ST_GATING = 3'd2;
  localparam logic [2:0] ST_GATED  = 3'd3;
  localparam logic [2:0] ST_WAKE   = 3'd4;

  typedef enum logic [2:0] {
    DCG_IDLE   = ST_IDLE,
    DCG_BUSY   = ST_BUSY,
    DCG_GATING = ST_GATING,
    DCG_GATED  = ST_GATED,
    DCG_WAKE   = ST_WAKE
  } dcg_req_state_e;

  // Testbus layout: {state[2:0], fwd_req, r_dcg_en, cnt[2:0]}
  localparam int TB_CNT_LSB   = 0;
  localparam int TB_EN_BIT    = 3;
  localparam int TB_FWD_BIT   = 4;
  localparam int TB_STATE_LSB = 5;

  function automatic logic [7:0] dcg_testbus_pack(
    input dcg_req_state_e st,
    input logic           fwd,
    input logic           en,
    input logic [2:0]     cnt
  );
    logic [7:0] tb;
    tb                     = '0;
    tb[TB_STATE_LSB +: 3]  = st;
    tb[TB_FWD_BIT]         = fwd;
    tb[TB_EN_BIT]          = en;
    tb[TB_CNT_LSB +: 3]    = cnt;
    return tb;
  endfunction

endpackage

// File: rtl/c3aibadapt_avmm_dcg_req.sv
// Requester side of the AVMM dynamic clock gating handshake. Runs on the
// free-running AVMM clock, wakes the gated clock when a transaction is
// pending, forwards it once the clock has restarted, and gates the clock
// again after a run of idle cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | clock running, no transaction; idle counter running
// BUSY    | transaction forwarded (fwd_req high) until fwd_done
// GATING  | single cycle, gate pulse issued to the DCG cell
// GATED   | clock gated, waiting for traffic or DCG disable
// WAKE    | ungate pulse issued, waiting WAKE_CYC cycles for the clock
module c3aibadapt_avmm_dcg_req
  import c3aibadapt_avmm_dcg_pkg::*;
#(
  parameter int WAKE_CYC = DCG_WAKE_CYC_DEF,
  parameter int IDLE_CYC = DCG_IDLE_CYC_DEF,
  parameter int CNT_W    = DCG_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r_dcg_en,
  input  logic       txn_req,
  output logic       txn_ack,
  output logic       fwd_req,
  input  logic       fwd_done,
  output logic       dcg_ungate,
  output logic       dcg_gate,
  output logic       clk_active,
  output logic [7:0] dcg_req_testbus
);

  localparam logic [CNT_W-1:0] CNT_IDLE = CNT_W'(IDLE_CYC);
  localparam logic [CNT_W-1:0] CNT_WAKE = CNT_W'(WAKE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dcg_req_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fwd_req_q, dcg_gate_q, dcg_ungate_q, clk_active_q;
  logic wake_cond;

  // Traffic or a DCG disable both force the clock back on.
  assign wake_cond = txn_req | ~r_dcg_en;

  // Next-state and shared down-counter: idle timeout in IDLE, restart wait in WAKE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DCG_IDLE: begin
        if (txn_req) begin
          // Transaction beats an idle expiry in the same cycle.
          state_d = DCG_BUSY;
          cnt_d   = CNT_IDLE;
        end else if (!r_dcg_en) begin
          cnt_d = CNT_IDLE;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = DCG_GATING;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DCG_BUSY: begin
        if (fwd_done) begin
          state_d = DCG_IDLE;
          cnt_d   = CNT_IDLE;
        end
      end
      DCG_GATING: begin
        if (wake_cond) begin
          state_d = DCG_WAKE;
          cnt_d   = CNT_WAKE;
        end else begin
          state_d = DCG_GATED;
        end
      end
      DCG_GATED: begin
        if (wake_cond) begin
          state_d = DCG_WAKE;
          cnt_d   = CNT_WAKE;
        end
      end
      DCG_WAKE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = DCG_IDLE;
          cnt_d   = CNT_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = DCG_IDLE;
        cnt_d   = CNT_IDLE;
      end
    endcase
  end

  // State and counter registers; the DCG cell also resets ungated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DCG_IDLE;
      cnt_q   <= CNT_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs toward the clock cell are decoded from the next state and
  // registered so they change only at the edge, never glitching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_req_q    <= 1'b0;
      dcg_gate_q   <= 1'b0;
      dcg_ungate_q <= 1'b0;
      clk_active_q <= 1'b1;
    end else begin
      fwd_req_q    <= (state_d == DCG_BUSY);
      dcg_gate_q   <= (state_d == DCG_GATING);
      dcg_ungate_q <= (state_d == DCG_WAKE) && (state_q != DCG_WAKE);
      clk_active_q <= (state_d != DCG_GATED);
    end
  end

  assign txn_ack    = txn_req & (state_q == DCG_IDLE);
  assign fwd_req    = fwd_req_q;
  assign dcg_gate   = dcg_gate_q;
  assign dcg_ungate = dcg_ungate_q;
  assign clk_active = clk_active_q;

  assign dcg_req_testbus = dcg_testbus_pack(state_q, fwd_req_q, r_dcg_en, cnt_q[2:0]);

endmodule

// File: tb/tb_c3aibadapt_avmm_dcg_req.sv
// Directed bench for the AVMM DCG requester (WAKE_CYC=4, IDLE_CYC=16).
module tb_c3aibadapt_avmm_dcg_req;

  logic       clk = 1'b0;
  logic       rst_n, r_dcg_en, txn_req, fwd_done;
  logic       txn_ack, fwd_req, dcg_ungate, dcg_gate, clk_active;
  logic [7:0] dcg_req_testbus;

  int n_chk    = 0;
  int n_pass   = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  c3aibadapt_avmm_dcg_req #(
    .WAKE_CYC(4),
    .IDLE_CYC(16),
    .CNT_W   (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r_dcg_en       (r_dcg_en),
    .txn_req        (txn_req),
    .txn_ack        (txn_ack),
    .fwd_req        (fwd_req),
    .fwd_done       (fwd_done),
    .dcg_ungate     (dcg_ungate),
    .dcg_gate       (dcg_gate),
    .clk_active     (clk_active),
    .dcg_req_testbus(dcg_req_testbus)
  );

  always @(negedge clk) begin
    if (dcg_gate && dcg_ungate) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gate(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (dcg_gate) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle_run(input int n, output int gates, output int ungates, output int inact);
    gates   = 0;
    ungates = 0;
    inact   = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (dcg_gate) gates++;
      if (dcg_ungate) ungates++;
      if (!clk_active) inact++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, u, ia;
    rst_n    = 1'b0;
    r_dcg_en = 1'b1;
    txn_req  = 1'b0;
    fwd_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;

    // cycle 1: reset state
    check("rst_fwd_req",    32'(fwd_req), 0);
    check("rst_gate",       32'(dcg_gate), 0);
    check("rst_ungate",     32'(dcg_ungate), 0);
    check("rst_clk_active", 32'(clk_active), 1);
    check("rst_txn_ack",    32'(txn_ack), 0);
    check("rst_testbus",    32'(dcg_req_testbus), 32'h08);

    // idle expiry: gate at cycle 17, clock inactive from 18
    wait_gate(n);
    check("gate_cycle", 32'(n + 1), 17);
    tick;
    check("gated_clk_active", 32'(clk_active), 0);
    check("gated_state",      32'(dcg_req_testbus[7:5]), 3);
    check("gate_one_cycle",   32'(dcg_gate), 0);

    // wake from GATED: ungate at t+1, ack at t+5, fwd_req at t+6
    tick;
    txn_req = 1'b1;
    #1;
    check("gated_no_ack", 32'(txn_ack), 0);
    tick;
    check("wake_ungate",  32'(dcg_ungate), 1);
    check("wake_testbus", 32'(dcg_req_testbus), 32'h8C);
    tick;
    check("ungate_one_cycle", 32'(dcg_ungate), 0);
    check("wake_no_ack",      32'(txn_ack), 0);
    tick;
    tick;
    check("wake_last_no_ack", 32'(txn_ack), 0);
    tick;
    check("wake_ack",          32'(txn_ack), 1);
    check("wake_ack_no_fwd",   32'(fwd_req), 0);
    tick;
    txn_req = 1'b0;
    #1;
    check("busy_fwd_req", 32'(fwd_req), 1);
    check("busy_no_ack",  32'(txn_ack), 0);
    tick;
    tick;
    check("busy_fwd_held", 32'(fwd_req), 1);

    // fwd_done then idle: fwd_req drops next cycle, gate 16 cycles later
    fwd_done = 1'b1;
    tick;
    fwd_done = 1'b0;
    #1;
    check("done_fwd_drop",    32'(fwd_req), 0);
    check("done_idle_tb",     32'(dcg_req_testbus), 32'h08);
    wait_gate(n);
    check("gate_after_done",  32'(n), 16);
    tick;
    check("regated_clk_active", 32'(clk_active), 0);

    // txn_req in the last idle cycle wins over gating
    txn_req = 1'b1;
    tick;
    repeat (4) tick;
    #1;
    check("wake2_ack", 32'(txn_ack), 1);
    tick;
    txn_req = 1'b0;
    check("busy2_fwd_req", 32'(fwd_req), 1);
    tick;
    fwd_done = 1'b1;
    tick;
    fwd_done = 1'b0;
    idle_run(15, g, u, ia);
    check("no_gate_before_expiry", 32'(g), 0);
    txn_req = 1'b1;
    #1;
    check("expiry_cycle_ack",     32'(txn_ack), 1);
    check("expiry_cycle_testbus", 32'(dcg_req_testbus), 32'h09);
    tick;
    check("txn_wins_no_gate", 32'(dcg_gate), 0);
    check("txn_wins_fwd_req", 32'(fwd_req), 1);
    txn_req = 1'b0;

    // DCG disabled: 100 idle cycles, no pulses; back-to-back transactions
    r_dcg_en = 1'b0;
    tick;
    fwd_done = 1'b1;
    tick;
    fwd_done = 1'b0;
    idle_run(100, g, u, ia);
    check("dis_gates",   32'(g), 0);
    check("dis_ungates", 32'(u), 0);
    check("dis_inact",   32'(ia), 0);
    check("dis_testbus", 32'(dcg_req_testbus), 32'h00);
    txn_req = 1'b1;
    #1;
    check("b2b_first_ack", 32'(txn_ack), 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("b2b_fwd_req", 32'(fwd_req), 1);
      check("b2b_busy_no_ack", 32'(txn_ack), 0);
      fwd_done = 1'b1;
      #1;
      check("b2b_done_no_ack", 32'(txn_ack), 0);
      tick;
      fwd_done = 1'b0;
      #1;
      check("b2b_ack_after_done", 32'(txn_ack), 1);
      check("b2b_fwd_dropped",    32'(fwd_req), 0);
    end
    tick;
    txn_req = 1'b0;
    check("b2b_last_fwd", 32'(fwd_req), 1);
    fwd_done = 1'b1;
    tick;
    fwd_done = 1'b0;

    // disable while GATED: single ungate, then stay in IDLE
    r_dcg_en = 1'b1;
    wait_gate(n);
    check("gate_reenable", 32'(n), 16);
    tick;
    tick;
    check("gated2_clk_active", 32'(clk_active), 0);
    r_dcg_en = 1'b0;
    tick;
    check("dis_wake_ungate", 32'(dcg_ungate), 1);
    idle_run(30, g, u, ia);
    check("dis_wake_more_ungates", 32'(u), 0);
    check("dis_wake_gates",        32'(g), 0);
    check("dis_wake_inact",        32'(ia), 0);
    check("dis_wake_testbus",      32'(dcg_req_testbus), 32'h00);

    // reset while BUSY aborts the forwarded transaction
    r_dcg_en = 1'b1;
    txn_req  = 1'b1;
    #1;
    check("pre_rst_ack", 32'(txn_ack), 1);
    tick;
    txn_req = 1'b0;
    check("pre_rst_fwd", 32'(fwd_req), 1);
    tick;
    rst_n = 1'b0;
    tick;
    check("rst_busy_fwd",        32'(fwd_req), 0);
    check("rst_busy_testbus",    32'(dcg_req_testbus), 32'h08);
    check("rst_busy_gate",       32'(dcg_gate), 0);
    check("rst_busy_ungate",     32'(dcg_ungate), 0);
    check("rst_busy_clk_active", 32'(clk_active), 1);
    tick;
    rst_n = 1'b1;
    idle_run(5, g, u, ia);
    check("post_rst_gates",   32'(g), 0);
    check("post_rst_ungates", 32'(u), 0);
    check("post_rst_fwd",     32'(fwd_req), 0);

    check("no_gate_ungate_overlap", 32'(both_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c3aibadapt_avmm_dcg_req.md
Name: c3aibadapt_avmm_dcg_req

Overview:
- Requester side of the AVMM dynamic clock gating (DCG) handshake.
- Runs on the free-running (pre-gate) AVMM clock and watches pending AVMM transactions from the SR link.
- Issues one-cycle ungate/gate pulses to the DCG cell, and forwards a transaction only after the gated clock has had WAKE_CYC cycles to restart.
- Gates the clock again after IDLE_CYC idle cycles.

Parameters:
- WAKE_CYC, 4: cycles spent in WAKE after the ungate pulse before a transaction may be accepted; must cover the DCG sync/ungate latency; legal range ≥1.
- IDLE_CYC, 16: consecutive idle cycles before the gate pulse is issued; legal range ≥1.
- CNT_W, 5: counter width; must satisfy 2^CNT_W > max(WAKE_CYC, IDLE_CYC).

Ports:
- clk  in  1  free-running AVMM clock (pre-SCG/DCG).
- rst_n  in  1  reset, synchronous, active-low.
- r_dcg_en  in  1  CSR: DCG enable; 0 means the clock is never gated.
- txn_req  in  1  level; a transaction is pending upstream.
- txn_ack  out  1  one-cycle accept pulse to upstream.
- fwd_req  out  1  level; transaction forwarded to AVMM logic, held until fwd_done.
- fwd_done  in  1  one-cycle completion pulse from AVMM logic.
- dcg_ungate  out  1  one-cycle ungate pulse to the DCG cell.
- dcg_gate  out  1  one-cycle gate pulse to the DCG cell.
- clk_active  out  1  1 unless state is GATED.
- dcg_req_testbus  out  8  {state[2:0], fwd_req, r_dcg_en, cnt[2:0]}.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, cnt=IDLE_CYC, fwd_req=0, dcg_gate=0, dcg_ungate=0, clk_active=1, txn_ack=0.
  - The DCG cell resets ungated, so the two sides start consistent.
  - Reset mid-operation aborts any forwarded transaction; fwd_req drops at the next edge.
- States: IDLE, BUSY, GATING, GATED, WAKE (3-bit encoding).
- txn_ack (combinational): txn_req & (state==IDLE).
- IDLE:
  - txn_req → BUSY; fwd_req=1 from the next cycle.
  - Otherwise, when r_dcg_en=1, cnt decrements each cycle. At cnt==1 with no txn_req → GATING.
  - With r_dcg_en=0, cnt holds at IDLE_CYC.
- BUSY:
  - fwd_req held high.
  - fwd_done → IDLE next cycle, fwd_req=0, cnt reloaded to IDLE_CYC.
  - txn_req ignored (txn_ack=0) while BUSY.
- GATING (exactly one cycle, dcg_gate=1):
  - txn_req or r_dcg_en=0 → WAKE.
  - Otherwise → GATED.
- GATED:
  - clk_active=0.
  - txn_req or r_dcg_en falling to 0 → WAKE.
- WAKE:
  - dcg_ungate=1 in the first WAKE cycle only; cnt loaded WAKE_CYC on entry and decrements.
  - When cnt reaches 1 → IDLE (cnt=IDLE_CYC).
  - A pending txn_req is acked in the first IDLE cycle.
- Latencies:
  - txn_req seen in GATED at cycle t → dcg_ungate at t+1, IDLE at t+1+WAKE_CYC (txn_ack), fwd_req at t+2+WAKE_CYC.
  - fwd_done at cycle t (no further txn_req) → dcg_gate at t+1+IDLE_CYC.
- Simultaneous events:
  - Idle expiry in the same cycle as txn_req: the transaction wins, no gate.
  - fwd_done with txn_req already high: IDLE for one cycle, then ack.
- r_dcg_en=0 in IDLE/BUSY: no pulses are ever issued.
- Outputs dcg_gate, dcg_ungate, fwd_req and clk_active are registered (glitch-free toward clock-cell logic).
- The ungate and gate pulses are never asserted in the same cycle.

Decomposition:
- Package c3aibadapt_avmm_dcg_pkg holds:
  - the state enum and encodings;
  - testbus field offsets;
  - the default WAKE_CYC/IDLE_CYC constants, shared with the DCG-side wait count.
- No sub-module: FSM plus one shared down-counter, roughly 150–200 lines.

Test Plan:
- Reset, r_dcg_en=1, no traffic, IDLE_CYC=16 → dcg_gate pulse at cycle 17 after reset release; clk_active=0 from cycle 18.
- In GATED, txn_req at cycle 10 (WAKE_CYC=4) → dcg_ungate at 11, txn_ack at 15, fwd_req high at 16.
- fwd_done at cycle 20, then no traffic → fwd_req low at 21, dcg_gate exactly at 37; a txn_req at 36 instead → no gate, txn_ack at 36.
- r_dcg_en=0 with 100 cycles idle → dcg_gate never pulses; back-to-back transactions acked one cycle after each fwd_done.
- r_dcg_en cleared while GATED → one dcg_ungate, then IDLE; no later gate.
- rst_n low while BUSY with fwd_req=1 → fwd_req=0 and state=IDLE at the next edge; no pulse emitted.
